// File: rtl/mux8_rr_arbiter_pkg.sv
// rtl/mux8_rr_arbiter_pkg.sv - shared constants, state type and helpers for the mux8 round-robin arbiter
package mux8_rr_arbiter_pkg;

  localparam int N_REQ  = 8;
  localparam int SEL_W  = 3;
  localparam int HOLD_W = 4;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  // One-hot decode of a requester index
  function automatic logic [N_REQ-1:0] onehot8(input logic [SEL_W-1:0] i);
    return N_REQ'(1) << i;
  endfunction

endpackage

// File: rtl/mux8_rr_arbiter_pick.sv
// rtl/mux8_rr_arbiter_pick.sv - combinational first-set-bit search with wrap and optional sole-bit exclusion
module rr_pick8
  import mux8_rr_arbiter_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [SEL_W-1:0] start,
  input  logic [SEL_W-1:0] excl,
  input  logic             excl_en,
  output logic             found,
  output logic [SEL_W-1:0] idx
);

  logic [N_REQ-1:0] elig;
  logic [SEL_W-1:0] cand;

  // Mask the excluded bit unless it is the only request, then scan from start with wrap;
  // the scan runs backwards so the candidate nearest to start is the last one written.
  always_comb begin
    elig  = req;
    found = 1'b0;
    idx   = start;
    cand  = '0;
    if (excl_en && ((req & ~onehot8(excl)) != '0)) begin
      elig[excl] = 1'b0;
    end
    for (int k = N_REQ - 1; k >= 0; k--) begin
      cand = start + SEL_W'(k);
      if (elig[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
    end
  end

endmodule

// File: rtl/mux8_rr_arbiter.sv
// rtl/mux8_rr_arbiter.sv - round-robin owner of the Mux_81 select lines with a bounded hold time
module mux8_rr_arbiter
  import mux8_rr_arbiter_pkg::*;
#(
  parameter int MAX_HOLD = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req,
  output logic [N_REQ-1:0] gnt,
  output logic [SEL_W-1:0] sel,   // sel[2:0] -> Mux_81 a2/a1/a0
  output logic             busy
);

  if (MAX_HOLD < 1 || MAX_HOLD > 15) begin : g_bad_max_hold
    $error("mux8_rr_arbiter: MAX_HOLD must be within 1..15");
  end

  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

  state_t              state;
  logic [SEL_W-1:0]    cur;
  logic [SEL_W-1:0]    ptr;
  logic [HOLD_W-1:0]   hold_cnt;

  logic                in_busy;
  logic                release_now;
  logic [SEL_W-1:0]    pick_start;
  logic                pick_found;
  logic [SEL_W-1:0]    pick_idx;

  // While busy the search begins just past the current owner, so the owner only
  // keeps the mux across a release when nobody else is asking for it.
  assign in_busy     = (state == BUSY);
  assign pick_start  = in_busy ? (cur + SEL_W'(1)) : ptr;
  assign release_now = in_busy && (!req[cur] || (hold_cnt == HOLD_LAST));

  rr_pick8 u_pick (
    .req     (req),
    .start   (pick_start),
    .excl    (cur),
    .excl_en (in_busy),
    .found   (pick_found),
    .idx     (pick_idx)
  );

  // Grant FSM: all outputs registered; sel keeps the last owner while idle
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cur      <= '0;
      ptr      <= '0;
      hold_cnt <= '0;
      gnt      <= '0;
      sel      <= '0;
      busy     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_found) begin
            state    <= BUSY;
            cur      <= pick_idx;
            hold_cnt <= '0;
            gnt      <= onehot8(pick_idx);
            sel      <= pick_idx;
            busy     <= 1'b1;
          end
        end
        BUSY: begin
          if (release_now) begin
            ptr <= cur + SEL_W'(1);
            if (pick_found) begin
              cur      <= pick_idx;
              hold_cnt <= '0;
              gnt      <= onehot8(pick_idx);
              sel      <= pick_idx;
            end else begin
              state <= IDLE;
              gnt   <= '0;
              busy  <= 1'b0;
            end
          end else begin
            hold_cnt <= hold_cnt + HOLD_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
